argon_alu_sequencer: RTL and testbench

Drives the ArgonALU control strobes and shared 16-bit bus so that a client can issue one complete ALU operation as a single request/response transaction. Each accepted request loads operand A, operand B, the optional flags word F and the opcode into the ALU, then reads back result Y and flags F. The block sits between the CPU control logic (or testbench) and the ArgonALU instance, and it is the only master of the ALU's strobe wires.

---
 rtl/argon_alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_argon_alu_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/argon_alu_sequencer.sv
// rtl/argon_alu_sequencer.sv - sequences one ArgonALU operation (load A/B/F/op, read Y/F) per request
// Sole master of the ALU strobes; each request becomes one response with optional timeout flag.
module argon_alu_sequencer #(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [OP_W-1:0] i_req_op,
    input  logic [15:0]     i_req_a,
    input  logic [15:0]     i_req_b,
    input  logic [15:0]     i_req_f,
    input  logic            i_req_load_f,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [15:0]     o_rsp_y,
    output logic [15:0]     o_rsp_f,
    output logic            o_rsp_timeout,
    output logic            o_busy,
    output logic [15:0]     o_alu_bus,
    input  logic [15:0]     i_alu_bus,
    input  logic            i_alu_bus_valid,
    output logic            o_latchA,
    output logic            o_latchB,
    output logic            o_latchF,
    output logic            o_latchOp,
    output logic            o_outputY,
    output logic            o_outputF
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_A, S_LD_B, S_LD_F, S_LD_OP, S_RD_Y, S_RD_F, S_RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [15:0]     f_q, f_d;
    logic            load_f_q, load_f_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [15:0]     rsp_y_q, rsp_y_d;
    logic [15:0]     rsp_f_q, rsp_f_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            f_q           <= '0;
            load_f_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_y_q       <= '0;
            rsp_f_q       <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            f_q           <= f_d;
            load_f_q      <= load_f_d;
            cnt_q         <= cnt_d;
            rsp_y_q       <= rsp_y_d;
            rsp_f_q       <= rsp_f_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        f_d           = f_q;
        load_f_d      = load_f_q;
        cnt_d         = cnt_q;
        rsp_y_d       = rsp_y_q;
        rsp_f_d       = rsp_f_q;
        rsp_timeout_d = rsp_timeout_q;
        o_req_ready   = 1'b0;
        o_rsp_valid   = 1'b0;
        o_alu_bus     = 16'h0000;
        o_latchA      = 1'b0;
        o_latchB      = 1'b0;
        o_latchF      = 1'b0;
        o_latchOp     = 1'b0;
        o_outputY     = 1'b0;
        o_outputF     = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    op_d          = i_req_op;
                    a_d           = i_req_a;
                    b_d           = i_req_b;
                    f_d           = i_req_f;
                    load_f_d      = i_req_load_f;
                    rsp_timeout_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_LD_A;
                end
            end
            S_LD_A: begin
                o_alu_bus = a_q;
                o_latchA  = 1'b1;
                state_d   = S_LD_B;
            end
            S_LD_B: begin
                o_alu_bus = b_q;
                o_latchB  = 1'b1;
                state_d   = load_f_q ? S_LD_F : S_LD_OP;
            end
            S_LD_F: begin
                o_alu_bus = f_q;
                o_latchF  = 1'b1;
                state_d   = S_LD_OP;
            end
            S_LD_OP: begin
                o_alu_bus = 16'(op_q);
                o_latchOp = 1'b1;
                state_d   = S_RD_Y;
            end
            S_RD_Y: begin
                o_outputY = 1'b1;
                if (i_alu_bus_valid) begin
                    rsp_y_d = i_alu_bus;
                    cnt_d   = '0;
                    state_d = S_RD_F;
                end else if (cnt_q == CNT_LAST) begin
                    // A missing Y makes F meaningless too, so skip RD_F entirely
                    rsp_y_d       = 16'hFFFF;
                    rsp_f_d       = 16'hFFFF;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RD_F: begin
                o_outputF = 1'b1;
                if (i_alu_bus_valid) begin
                    rsp_f_d = i_alu_bus;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_f_d       = 16'hFFFF;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rsp_y       = rsp_y_q;
    assign o_rsp_f       = rsp_f_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_argon_alu_sequencer.sv
// tb/tb_argon_alu_sequencer.sv - directed scoreboard bench for argon_alu_sequencer
module tb_argon_alu_sequencer;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [3:0]  i_req_op;
    logic [15:0] i_req_a, i_req_b, i_req_f;
    logic        i_req_load_f;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [15:0] o_rsp_y, o_rsp_f;
    logic        o_rsp_timeout;
    logic        o_busy;
    logic [15:0] o_alu_bus;
    logic [15:0] i_alu_bus;
    logic        i_alu_bus_valid;
    logic        o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF;

    argon_alu_sequencer #(.OP_W(4), .TIMEOUT(8)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_f(i_req_f),
        .i_req_load_f(i_req_load_f),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_y(o_rsp_y), .o_rsp_f(o_rsp_f), .o_rsp_timeout(o_rsp_timeout),
        .o_busy(o_busy), .o_alu_bus(o_alu_bus),
        .i_alu_bus(i_alu_bus), .i_alu_bus_valid(i_alu_bus_valid),
        .o_latchA(o_latchA), .o_latchB(o_latchB), .o_latchF(o_latchF),
        .o_latchOp(o_latchOp), .o_outputY(o_outputY), .o_outputF(o_outputF)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [15:0] y;
        logic [15:0] f;
        logic        to;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    localparam int NEVER = 255;
    localparam int TMO   = 8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // 0 none, 1 A, 2 B, 3 F, 4 Op, 5 outY, 6 outF, 7 more than one
    function automatic int strobe_code();
        int n;
        int code;
        n = int'(o_latchA) + int'(o_latchB) + int'(o_latchF) + int'(o_latchOp)
          + int'(o_outputY) + int'(o_outputF);
        code = 0;
        if (o_latchA)  code = 1;
        if (o_latchB)  code = 2;
        if (o_latchF)  code = 3;
        if (o_latchOp) code = 4;
        if (o_outputY) code = 5;
        if (o_outputF) code = 6;
        if (n > 1) code = 7;
        return code;
    endfunction

    // Called at a negedge with the DUT idle; leaves the bench at a negedge.
    task automatic run_txn(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] f, input logic lf,
                           input logic [15:0] yr, input logic [15:0] fr,
                           input int dy, input int df, input int hold, input bit btb,
                           input int exp_lat);
        int   seq[$];
        int   ny, nf, lat, bad, hbad, ycnt, fcnt, code, ecode;
        logic [15:0] ebus, y0, f0;
        logic to0;
        rsp_t e, got;

        ny = (dy == NEVER) ? TMO : dy + 1;
        nf = (dy == NEVER) ? 0 : ((df == NEVER) ? TMO : df + 1);
        seq.push_back(1);
        seq.push_back(2);
        if (lf) seq.push_back(3);
        seq.push_back(4);
        for (int i = 0; i < ny; i++) seq.push_back(5);
        for (int i = 0; i < nf; i++) seq.push_back(6);

        e.y  = (dy == NEVER) ? 16'hFFFF : yr;
        e.f  = (dy == NEVER || df == NEVER) ? 16'hFFFF : fr;
        e.to = (dy == NEVER || df == NEVER);
        sb_q.push_back(e);

        chk({tag, ".req_ready"}, o_req_ready, 1'b1);
        i_req_valid  = 1'b1;
        i_req_op     = op;
        i_req_a      = a;
        i_req_b      = b;
        i_req_f      = f;
        i_req_load_f = lf;

        lat = -1; bad = 0; ycnt = 0; fcnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge i_Clk);
            if (c == 1) i_req_valid = 1'b0;
            if (o_rsp_valid) begin
                lat = c;
                break;
            end
            code  = strobe_code();
            ecode = (seq.size() > 0) ? seq.pop_front() : 0;
            case (ecode)
                1: ebus = a;
                2: ebus = b;
                3: ebus = f;
                4: ebus = {12'h000, op};
                default: ebus = 16'h0000;
            endcase
            if (code != ecode || o_alu_bus !== ebus) bad++;
            if (o_outputY) begin
                i_alu_bus_valid = (ycnt == dy);
                i_alu_bus       = yr;
                ycnt++;
            end else if (o_outputF) begin
                i_alu_bus_valid = (fcnt == df);
                i_alu_bus       = fr;
                fcnt++;
            end else begin
                i_alu_bus_valid = 1'b0;
                i_alu_bus       = 16'h0000;
            end
        end
        i_alu_bus_valid = 1'b0;
        i_alu_bus       = 16'h0000;
        chk({tag, ".strobe_seq"}, bad + seq.size(), 0);
        chk({tag, ".latency"}, lat, exp_lat);

        y0 = o_rsp_y; f0 = o_rsp_f; to0 = o_rsp_timeout; hbad = 0;
        for (int h = 0; h < hold; h++) begin
            i_req_valid = ~i_req_valid;
            @(negedge i_Clk);
            if (!o_rsp_valid || o_req_ready || o_rsp_y !== y0 || o_rsp_f !== f0
                || o_rsp_timeout !== to0) hbad++;
        end
        if (hold > 0) chk({tag, ".hold_stable"}, hbad, 0);

        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk({tag, ".rsp_y"}, o_rsp_y, got.y);
            chk({tag, ".rsp_f"}, o_rsp_f, got.f);
            chk({tag, ".rsp_timeout"}, o_rsp_timeout, got.to);
        end

        i_rsp_ready = 1'b1;
        i_req_valid = btb;
        @(negedge i_Clk);
        i_rsp_ready = 1'b0;
        chk({tag, ".rsp_valid_drop"}, o_rsp_valid, 1'b0);
        chk({tag, ".no_accept_on_consume"}, o_busy, 1'b0);
        if (!btb) i_req_valid = 1'b0;
    endtask

    initial begin
        int seen;
        i_Reset = 1'b1;
        i_req_valid = 1'b0; i_req_op = '0; i_req_a = '0; i_req_b = '0; i_req_f = '0;
        i_req_load_f = 1'b0; i_rsp_ready = 1'b0; i_alu_bus = '0; i_alu_bus_valid = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;
        @(negedge i_Clk);

        chk("reset.req_ready", o_req_ready, 1'b1);
        chk("reset.strobes", strobe_code(), 0);
        chk("reset.bus", o_alu_bus, 16'h0000);
        chk("reset.busy", o_busy, 1'b0);
        chk("reset.rsp", {o_rsp_valid, o_rsp_timeout, o_rsp_y, o_rsp_f}, 34'h0);

        // Abandon a transaction in LD_B with an asynchronous reset.
        i_req_valid = 1'b1; i_req_a = 16'hAAAA; i_req_b = 16'h5555; i_req_load_f = 1'b1;
        @(negedge i_Clk);
        i_req_valid = 1'b0;
        @(negedge i_Clk);
        chk("midreset.in_ld_b", {o_latchB, o_alu_bus}, {1'b1, 16'h5555});
        #2 i_Reset = 1'b1;
        #1;
        chk("midreset.strobes", strobe_code(), 0);
        chk("midreset.bus_busy", {o_alu_bus, o_busy}, 17'h0);
        #1 i_Reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_Clk);
            if (o_rsp_valid || strobe_code() != 0) seen++;
        end
        chk("midreset.no_rsp", seen, 0);

        run_txn("basic_lf1", 4'd3, 16'h1234, 16'h0011, 16'h0000, 1'b1,
                16'h1245, 16'h0000, 0, 0, 0, 1'b0, 7);
        run_txn("basic_lf0", 4'd3, 16'h1234, 16'h0011, 16'h0000, 1'b0,
                16'h1245, 16'h0000, 0, 0, 0, 1'b0, 6);
        run_txn("delay_y3", 4'd9, 16'hBEEF, 16'h0102, 16'h00F0, 1'b1,
                16'hC0DE, 16'h0081, 3, 1, 0, 1'b0, 4 + 1 + 4 + 2);
        run_txn("y_timeout", 4'hF, 16'h0001, 16'h0002, 16'h0003, 1'b1,
                16'h7777, 16'h6666, NEVER, 0, 0, 1'b0, 4 + 1 + TMO);
        run_txn("f_timeout", 4'h1, 16'h4000, 16'h0004, 16'h0000, 1'b0,
                16'h4004, 16'h1111, 0, NEVER, 5, 1'b1, 4 + 0 + 1 + TMO);
        run_txn("after_btb", 4'h7, 16'hFFFF, 16'h0001, 16'h8000, 1'b1,
                16'h0000, 16'h0005, 0, 2, 0, 1'b0, 4 + 1 + 1 + 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
